// File: rtl/multi_blink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_blink_pkg
// Description : Shared encodings for the multi-channel LED blinker: config
//               mode codes, per-channel FSM state codes and the PWM width.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_blink_pkg;

    // Config mode codes presented on cfg_mode
    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_BURST = 2'd3;

    // Per-channel FSM states
    localparam logic [1:0] S_OFF    = 2'd0;
    localparam logic [1:0] S_ON     = 2'd1;
    localparam logic [1:0] S_PH_ON  = 2'd2;
    localparam logic [1:0] S_PH_OFF = 2'd3;

    // Width of the duty-cycle field and of the free-running PWM counter
    localparam int PWM_W = 8;

    // A state drives the LED when it is steady-on or in the lit blink phase
    function automatic logic state_lit(input logic [1:0] s);
        return (s == S_ON) || (s == S_PH_ON);
    endfunction

endpackage
`default_nettype wire

// File: rtl/blink_channel.sv
`default_nettype none
// ============================================================================
// Module      : blink_channel
// Description : One LED channel: latched config, phase counter, burst
//               counter and the OFF/ON/PH_ON/PH_OFF state machine.
//               Optional duty gating when MULTI_BLINK_PWM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module blink_channel
    import multi_blink_pkg::*;
#(
    parameter int HP_W = 16,
    parameter int BC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             wr,
    input  logic [1:0]       cfg_mode,
    input  logic [HP_W-1:0]  cfg_half_period,
    input  logic [BC_W-1:0]  cfg_burst,
`ifdef MULTI_BLINK_PWM_EN
    input  logic [PWM_W-1:0] cfg_duty,
    input  logic [PWM_W-1:0] pwm_cnt,
`endif
    output logic             led,
    output logic             busy,
    output logic             done
);

    logic [1:0]      r_state;
    logic [1:0]      r_mode;
    logic [HP_W-1:0] r_hp;
    logic [HP_W-1:0] r_cnt;
    logic [BC_W-1:0] r_rem;
    logic            r_led;
    logic            r_done;

    logic [HP_W-1:0] w_hp_eff;
    logic            w_active;
    logic            w_phase_end;
    logic            w_led_next;

    // A zero half period would never end a phase, so it behaves as one tick
    assign w_hp_eff    = (cfg_half_period == '0) ? HP_W'(1) : cfg_half_period;
    assign w_active    = (r_state == S_PH_ON) || (r_state == S_PH_OFF);
    assign w_phase_end = (r_cnt == (r_hp - HP_W'(1)));

`ifdef MULTI_BLINK_PWM_EN
    logic [PWM_W-1:0] r_duty;

    // Duty value is latched with the rest of the channel config
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_duty <= '0;
        else if (wr)
            r_duty <= cfg_duty;
    end

    assign w_led_next = state_lit(r_state) && (pwm_cnt < r_duty);
`else
    assign w_led_next = state_lit(r_state);
`endif

    // Channel FSM: a write always wins over a coincident tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_OFF;
            r_mode  <= MODE_OFF;
            r_hp    <= '0;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_led   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_led  <= w_led_next;
            if (wr) begin
                r_mode <= cfg_mode;
                r_hp   <= w_hp_eff;
                r_rem  <= cfg_burst;
                r_cnt  <= '0;
                case (cfg_mode)
                    MODE_OFF:   r_state <= S_OFF;
                    MODE_ON:    r_state <= S_ON;
                    MODE_BLINK: r_state <= S_PH_ON;
                    default: begin
                        // An empty burst completes straight away
                        if (cfg_burst == '0) begin
                            r_state <= S_OFF;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_PH_ON;
                        end
                    end
                endcase
            end else if (tick && w_active) begin
                if (w_phase_end) begin
                    r_cnt <= '0;
                    if (r_state == S_PH_ON) begin
                        r_state <= S_PH_OFF;
                    end else if (r_mode == MODE_BURST) begin
                        // End of an OFF phase consumes one burst cycle
                        if (r_rem <= BC_W'(1)) begin
                            r_rem   <= '0;
                            r_state <= S_OFF;
                            r_done  <= 1'b1;
                        end else begin
                            r_rem   <= r_rem - BC_W'(1);
                            r_state <= S_PH_ON;
                        end
                    end else begin
                        r_state <= S_PH_ON;
                    end
                end else begin
                    r_cnt <= r_cnt + HP_W'(1);
                end
            end
        end
    end

    assign led  = r_led;
    assign busy = w_active;
    assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/multi_blink.sv
`default_nettype none
// ============================================================================
// Module      : multi_blink
// Description : NUM_CH independent LED blinkers sharing one tick prescaler.
//               Owns the prescaler, write decode and (with the macro
//               MULTI_BLINK_PWM_EN defined) the free-running PWM counter
//               and the cfg_duty input.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_blink
    import multi_blink_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int PRESCALE = 10000,
    parameter int HP_W     = 16,
    parameter int BC_W     = 8,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [HP_W-1:0]   cfg_half_period,
    input  logic [BC_W-1:0]   cfg_burst,
`ifdef MULTI_BLINK_PWM_EN
    input  logic [PWM_W-1:0]  cfg_duty,
`endif
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);

    localparam int PRE_W = $clog2(PRESCALE);

    logic [PRE_W-1:0] r_pre;
    logic             w_tick;
    logic             w_ch_ok;

    // Shared prescaler; free-running, only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pre <= '0;
        else if (r_pre == PRE_W'(PRESCALE - 1))
            r_pre <= '0;
        else
            r_pre <= r_pre + PRE_W'(1);
    end

    assign w_tick  = (r_pre == PRE_W'(PRESCALE - 1));
    assign w_ch_ok = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));

`ifdef MULTI_BLINK_PWM_EN
    logic [PWM_W-1:0] r_pwm;

    // Free-running PWM counter shared by all channels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pwm <= '0;
        else
            r_pwm <= r_pwm + PWM_W'(1);
    end
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic w_wr;
        assign w_wr = cfg_we && w_ch_ok && (cfg_ch == CH_W'(i));

        blink_channel #(
            .HP_W (HP_W),
            .BC_W (BC_W)
        ) u_ch (
            .clk             (clk),
            .rst_n           (rst_n),
            .tick            (w_tick),
            .wr              (w_wr),
            .cfg_mode        (cfg_mode),
            .cfg_half_period (cfg_half_period),
            .cfg_burst       (cfg_burst),
`ifdef MULTI_BLINK_PWM_EN
            .cfg_duty        (cfg_duty),
            .pwm_cnt         (r_pwm),
`endif
            .led             (led[i]),
            .busy            (busy[i]),
            .done            (done[i])
        );
    end

endmodule
`default_nettype wire
